csr_trap_ctrl: RTL
==================

# csr_trap_ctrl

Machine-mode trap responder for the NPC single-issue core. It acts on the `ecall` and `mret` instructions once they are decoded, and owns the four M-mode CSRs (mstatus, mtvec, mepc, mcause). It executes Zicsr read/modify/write instructions. It sequences trap entry and return as a short stall-then-redirect handshake toward the PC/fetch logic. One-cycle event pulses are emitted so the DPI simulation monitor can log traps at the moment control actually transfers.

## Interface
Parameters:
- `MTVEC_RST`, default 32'h0000_0000: reset value of mtvec.
- `MSTATUS_RST`, default 32'h0000_1800: reset value of mstatus (MPP=2'b11).

Ports:
- `clk` input 1: single clock; all state updates on rising edge.
- `rst` input 1: synchronous, active-high reset.
- `valid` input 1: `inst`/`pc`/`rs1_data` describe an executing instruction this cycle.
- `inst` input 32: instruction word.
- `pc` input 32: address of `inst`.
- `rs1_data` input 32: GPR[rs1] value.
- `csr_rdata` output 32: old CSR value for Zicsr instructions; combinational; 0 otherwise.
- `stall` output 1: hold PC and pipeline; combinational.
- `redirect_valid` output 1: one-cycle pulse; fetch must load `redirect_pc`.
- `redirect_pc` output 32: redirect target; 0 when `redirect_valid`=0.
- `ecall_evt` output 1: pulse, coincident with a trap-entry redirect.
- `mret_evt` output 1: pulse, coincident with an mret redirect.

## Operation
Decode (only when `valid`=1 and state=IDLE):
- `ecall` is exactly 32'h0000_0073.
- `mret` is exactly 32'h3020_0073.
- Zicsr is opcode 7'b1110011 with funct3 in {001,010,011,101,110,111}.
- CSR address is `inst[31:20]`.
- Source operand is `rs1_data` for funct3[2]=0, and zero-extended `inst[19:15]` for funct3[2]=1.

CSR map:
- 0x300 mstatus
- 0x305 mtvec: bits[1:0] always written as 0 (direct mode only).
- 0x341 mepc: bits[1:0] always written as 0.
- 0x342 mcause
- Any other address reads 0 and ignores writes; no exception is raised.

CSR write rules:
- RW writes the source operand.
- RS writes old | src.
- RC writes old & ~src.
- RS and RC perform no write when `inst[19:15]`=0. RW always writes.
- The write commits at the end of the accept cycle. `csr_rdata` returns the pre-write value.

State machine:
- IDLE:
  - On `ecall`, go to TRAP and commit, at the same edge:
    - mepc <= `pc`
    - mcause <= 32'd11
    - mstatus.MPIE(bit7) <= MIE(bit3)
    - MIE <= 0
    - MPP(bits12:11) <= 2'b11
  - On `mret`, go to RET and commit, at the same edge:
    - MIE <= MPIE
    - MPIE <= 1
    - MPP <= 2'b11
  - Otherwise stay in IDLE.
- TRAP: `redirect_valid`=1, `redirect_pc`=mtvec, `ecall_evt`=1, then go to IDLE.
- RET: `redirect_valid`=1, `redirect_pc`=mepc, `mret_evt`=1, then go to IDLE.

Stall rule: `stall`=1 in the accept cycle of ecall/mret, and in TRAP/RET. `stall`=0 otherwise, including for Zicsr instructions.

Boundary and corner cases:
- `valid` is ignored in TRAP/RET. No decode and no CSR write occur there.
- A CSR written by instruction N is visible to instruction N+1. For example, mret immediately after `csrw mepc` jumps to the new value.
- A trap entered while mtvec is unwritten redirects to `MTVEC_RST`.
- Nested ecall at a handler's first instruction overwrites mepc and mcause. This is intended; no double-fault detection.

## Timing
- Reset:
  - State goes to IDLE.
  - mstatus=`MSTATUS_RST`, mtvec=`MTVEC_RST`, mepc=0, mcause=0.
  - All outputs are 0 in the cycle after `rst` is sampled high. `stall` and `csr_rdata` are 0 while `rst`=1.
- Reset mid-operation: `rst` in TRAP/RET cancels the redirect. No `redirect_valid` or evt pulse fires, and the CSRs take their reset values.
- Latency, ecall/mret accepted in cycle T:
  - CSR/mstatus update visible from T+1.
  - Redirect pulse in T+1.
  - IDLE again at T+2.
  - Fetch presents the target instruction at T+2 at the earliest.
- Zicsr: zero added latency; one instruction per cycle.
- `redirect_valid`, `ecall_evt` and `mret_evt` are registered-state decodes and glitch-free. Each is exactly one cycle wide.

## Test plan
- Reset, then `csrr mstatus` -> `csr_rdata`=32'h0000_1800, and all other outputs are 0.
- `csrw mtvec` with rs1_data=32'h8000_0103, then `csrr mtvec` -> `csr_rdata`=32'h8000_0100.
- ecall at pc=32'h8000_0040 with MIE=1 -> `stall`=1 for two cycles, then:
  - `redirect_valid`/`ecall_evt`=1 with `redirect_pc`=mtvec
  - mepc=32'h8000_0040, mcause=11
  - mstatus bit7=1, bit3=0
- `csrw mepc` to 32'h8000_0044 then mret -> `redirect_pc`=32'h8000_0044, `mret_evt`=1, MIE=1, MPIE=1.
- `csrrs` with rs1=x0 to mcause -> old value read, mcause unchanged. `csrrci` with zimm=5'h08 on mstatus=32'h1888 -> mstatus=32'h1880.
- `rst` asserted in the TRAP cycle -> no `redirect_valid`, and mepc=0 next cycle. `valid`+ecall held during TRAP -> exactly one trap is taken.

Source files
------------

// File: rtl/csr_trap_ctrl.sv
// Machine-mode trap responder: owns mstatus/mtvec/mepc/mcause, executes Zicsr,
// and sequences ecall/mret as a stall-then-redirect handshake toward fetch.
module csr_trap_ctrl #(
    parameter logic [31:0] MTVEC_RST   = 32'h0000_0000,
    parameter logic [31:0] MSTATUS_RST = 32'h0000_1800
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid,
    input  logic [31:0] inst,
    input  logic [31:0] pc,
    input  logic [31:0] rs1_data,
    output logic [31:0] csr_rdata,
    output logic        stall,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    output logic        ecall_evt,
    output logic        mret_evt
);

    typedef enum logic [1:0] {
        IDLE,
        TRAP,
        RET
    } state_t;

    state_t      state, state_nxt;
    logic [31:0] mstatus, mtvec, mepc, mcause;
    logic [31:0] csr_old, csr_src, csr_wval;
    logic [11:0] csr_addr;
    logic [4:0]  rs1_idx;
    logic [2:0]  funct3;
    logic        accept, is_ecall, is_mret, is_csr, csr_we;

    assign csr_addr = inst[31:20];
    assign rs1_idx  = inst[19:15];
    assign funct3   = inst[14:12];

    // Reset is folded into accept so nothing decodes or writes while rst is high.
    assign accept   = valid && (state == IDLE) && !rst;
    assign is_ecall = accept && (inst == 32'h0000_0073);
    assign is_mret  = accept && (inst == 32'h3020_0073);
    assign is_csr   = accept && (inst[6:0] == 7'b1110011) &&
                      (funct3 != 3'b000) && (funct3 != 3'b100);
    assign csr_we   = is_csr && ((funct3[1:0] == 2'b01) || (rs1_idx != 5'd0));
    assign csr_src  = funct3[2] ? {27'd0, rs1_idx} : rs1_data;

    always_comb begin
        case (csr_addr)
            12'h300: csr_old = mstatus;
            12'h305: csr_old = mtvec;
            12'h341: csr_old = mepc;
            12'h342: csr_old = mcause;
            default: csr_old = '0;
        endcase
    end

    always_comb begin
        case (funct3[1:0])
            2'b01:   csr_wval = csr_src;
            2'b10:   csr_wval = csr_old | csr_src;
            2'b11:   csr_wval = csr_old & ~csr_src;
            default: csr_wval = csr_old;
        endcase
    end

    always_comb begin
        state_nxt      = state;
        stall          = 1'b0;
        csr_rdata      = '0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        ecall_evt      = 1'b0;
        mret_evt       = 1'b0;
        case (state)
            IDLE: begin
                stall     = is_ecall || is_mret;
                csr_rdata = is_csr ? csr_old : '0;
                if (is_ecall)     state_nxt = TRAP;
                else if (is_mret) state_nxt = RET;
            end
            TRAP: begin
                state_nxt      = IDLE;
                stall          = !rst;
                redirect_valid = !rst;
                ecall_evt      = !rst;
                redirect_pc    = rst ? '0 : mtvec;
            end
            RET: begin
                state_nxt      = IDLE;
                stall          = !rst;
                redirect_valid = !rst;
                mret_evt       = !rst;
                redirect_pc    = rst ? '0 : mepc;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            mstatus <= MSTATUS_RST;
            mtvec   <= MTVEC_RST;
            mepc    <= '0;
            mcause  <= '0;
        end else begin
            state <= state_nxt;
            if (is_ecall) begin
                mepc           <= pc;
                mcause         <= 32'd11;
                mstatus[7]     <= mstatus[3];
                mstatus[3]     <= 1'b0;
                mstatus[12:11] <= 2'b11;
            end else if (is_mret) begin
                mstatus[3]     <= mstatus[7];
                mstatus[7]     <= 1'b1;
                mstatus[12:11] <= 2'b11;
            end else if (csr_we) begin
                case (csr_addr)
                    12'h300: mstatus <= csr_wval;
                    12'h305: mtvec   <= {csr_wval[31:2], 2'b00};
                    12'h341: mepc    <= {csr_wval[31:2], 2'b00};
                    12'h342: mcause  <= csr_wval;
                    default: ;
                endcase
            end
        end
    end

endmodule
